// File: rtl/fp_mult_pkg.sv
// Shared types and constants for the handshake-fed IEEE-754 single-precision multiplier.
package fp_mult_pkg;

  localparam int MANT_W   = 24;
  localparam int EXP_BIAS = 127;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_MSB = 22;

  localparam logic [31:0] QNAN     = 32'h7FC00000;
  localparam logic [31:0] POS_INF  = 32'h7F800000;
  localparam logic [31:0] NEG_INF  = 32'hFF800000;
  localparam logic [31:0] POS_ZERO = 32'h00000000;
  localparam logic [31:0] NEG_ZERO = 32'h80000000;

  typedef enum logic [2:0] {
    LOAD_A,
    REL_A,
    LOAD_B,
    REL_B,
    WAIT_START,
    MUL,
    NORM,
    DONE
  } state_t;

  function automatic logic [31:0] signed_inf(input logic s);
    return s ? NEG_INF : POS_INF;
  endfunction

  function automatic logic [31:0] signed_zero(input logic s);
    return s ? NEG_ZERO : POS_ZERO;
  endfunction

endpackage

// File: rtl/fp_mult_datapath.sv
// Operand registers, bit-serial shift-add significand multiplier, normaliser and packer.
module fp_mult_datapath
  import fp_mult_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_a,
  input  logic        load_b,
  input  logic        mul_init,
  input  logic        mul_step,
  input  logic        norm,
  input  logic [31:0] operand,
  output logic [31:0] result
);

  logic [31:0]            a_q, b_q;
  logic                   sign_q;
  logic signed [9:0]      exp_q;
  logic [2*MANT_W-1:0]    mcand_q;
  logic [MANT_W-1:0]      mplier_q;
  logic [2*MANT_W-1:0]    prod_q;
  logic [31:0]            res_q;
  logic [31:0]            res_d;

  logic [7:0]        exp_a, exp_b;
  logic              zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic signed [9:0] exp_n;
  logic [22:0]       frac_n;

  assign exp_a  = a_q[EXP_MSB:EXP_LSB];
  assign exp_b  = b_q[EXP_MSB:EXP_LSB];
  assign zero_a = (exp_a == 8'd0);
  assign zero_b = (exp_b == 8'd0);
  assign inf_a  = (exp_a == 8'hFF) && (a_q[FRAC_MSB:0] == 23'd0);
  assign inf_b  = (exp_b == 8'hFF) && (b_q[FRAC_MSB:0] == 23'd0);
  assign nan_a  = (exp_a == 8'hFF) && (a_q[FRAC_MSB:0] != 23'd0);
  assign nan_b  = (exp_b == 8'hFF) && (b_q[FRAC_MSB:0] != 23'd0);

  assign exp_n  = prod_q[2*MANT_W-1] ? exp_q + 10'sd1 : exp_q;
  assign frac_n = prod_q[2*MANT_W-1] ? prod_q[46:24] : prod_q[45:23];

  // Special operands take priority over range checks on the computed exponent.
  always_comb begin
    res_d = {sign_q, exp_n[7:0], frac_n};
    if (nan_a || nan_b) begin
      res_d = QNAN;
    end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
      res_d = QNAN;
    end else if (inf_a || inf_b) begin
      res_d = signed_inf(sign_q);
    end else if (zero_a || zero_b) begin
      res_d = signed_zero(sign_q);
    end else if (exp_n >= 10'sd255) begin
      res_d = signed_inf(sign_q);
    end else if (exp_n <= 10'sd0) begin
      res_d = signed_zero(sign_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      res_q    <= '0;
    end else begin
      if (load_a) a_q <= operand;
      if (load_b) b_q <= operand;
      if (mul_init) begin
        sign_q   <= a_q[SIGN_BIT] ^ b_q[SIGN_BIT];
        exp_q    <= 10'($signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - EXP_BIAS);
        mcand_q  <= {{MANT_W{1'b0}}, 1'b1, a_q[FRAC_MSB:0]};
        mplier_q <= {1'b1, b_q[FRAC_MSB:0]};
        prod_q   <= '0;
      end
      if (mul_step) begin
        if (mplier_q[0]) prod_q <= prod_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
      end
      if (norm) res_q <= res_d;
    end
  end

  assign result = res_q;

endmodule

// File: rtl/fp_mult_handshake.sv
// Control FSM: four-phase operand handshake, multiply sequencing and result handshake.
module fp_mult_handshake
  import fp_mult_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        startMul,
  input  logic        resultaccept,
  input  logic [31:0] Tempbus,
  output logic [31:0] ResultBus,
  input  logic        ready,
  output logic        accept,
  output logic        doneMul,
  output logic        resultready
);

  state_t     state_q;
  logic [4:0] cnt_q;
  logic       accept_q, done_q, rready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOAD_A;
      cnt_q    <= '0;
      accept_q <= 1'b0;
      done_q   <= 1'b0;
      rready_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        LOAD_A: if (ready) begin
          accept_q <= 1'b1;
          state_q  <= REL_A;
        end
        REL_A: if (!ready) begin
          accept_q <= 1'b0;
          state_q  <= LOAD_B;
        end
        LOAD_B: if (ready) begin
          accept_q <= 1'b1;
          state_q  <= REL_B;
        end
        REL_B: if (!ready) begin
          accept_q <= 1'b0;
          state_q  <= WAIT_START;
        end
        WAIT_START: if (startMul) begin
          cnt_q   <= '0;
          state_q <= MUL;
        end
        MUL: begin
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(MANT_W - 1)) state_q <= NORM;
        end
        NORM: begin
          done_q   <= 1'b1;
          rready_q <= 1'b1;
          state_q  <= DONE;
        end
        DONE: if (resultaccept) begin
          rready_q <= 1'b0;
          state_q  <= LOAD_A;
        end
        default: state_q <= LOAD_A;
      endcase
    end
  end

  fp_mult_datapath u_datapath (
    .clk      (clk),
    .rst      (rst),
    .load_a   ((state_q == LOAD_A) && ready),
    .load_b   ((state_q == LOAD_B) && ready),
    .mul_init ((state_q == WAIT_START) && startMul),
    .mul_step (state_q == MUL),
    .norm     (state_q == NORM),
    .operand  (Tempbus),
    .result   (ResultBus)
  );

  assign accept      = accept_q;
  assign doneMul     = done_q;
  assign resultready = rready_q;

endmodule

// File: tb/tb_fp_mult_handshake.sv
// Self-checking bench: directed cases plus random operands against an arithmetic reference model.
module tb_fp_mult_handshake;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        startMul = 1'b0;
  logic        resultaccept = 1'b0;
  logic [31:0] Tempbus = '0;
  logic [31:0] ResultBus;
  logic        ready = 1'b0;
  logic        accept;
  logic        doneMul;
  logic        resultready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fp_mult_handshake dut (
    .clk          (clk),
    .rst          (rst),
    .startMul     (startMul),
    .resultaccept (resultaccept),
    .Tempbus      (Tempbus),
    .ResultBus    (ResultBus),
    .ready        (ready),
    .accept       (accept),
    .doneMul      (doneMul),
    .resultready  (resultready)
  );

  // Reference: exact integer significand product, truncate, then the special-case rules.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        s;
    logic [47:0] p;
    logic [22:0] frac;
    int          e;
    ea = a[30:23]; eb = b[30:23];
    fa = a[22:0];  fb = b[22:0];
    s  = a[31] ^ b[31];
    if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0)) return 32'h7FC00000;
    if ((ea == 8'hFF && eb == 8'h00) || (ea == 8'h00 && eb == 8'hFF)) return 32'h7FC00000;
    if (ea == 8'hFF || eb == 8'hFF) return {s, 8'hFF, 23'd0};
    if (ea == 8'h00 || eb == 8'h00) return {s, 31'd0};
    p = 48'({1'b1, fa}) * 48'({1'b1, fb});
    e = int'(ea) + int'(eb) - 127;
    if (p[47]) begin
      e    = e + 1;
      frac = p[46:24];
    end else begin
      frac = p[45:23];
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0)   return {s, 31'd0};
    return {s, e[7:0], frac};
  endfunction

  task automatic do_reset();
    rst = 1'b1; ready = 1'b0; startMul = 1'b0; resultaccept = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic load_operand(input logic [31:0] v, input int hold);
    int k;
    Tempbus = v; ready = 1'b1; k = 0;
    while (accept !== 1'b1 && k < 10) begin
      @(posedge clk); #1; k++;
    end
    n_cmp++;
    if (k != 1) begin
      n_bad++;
      $display("FAIL accept_rise: operand %h accept after %0d cycles, want 1", v, k);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (accept !== 1'b1) begin
        n_bad++;
        $display("FAIL accept_hold: accept=%b want 1 while ready high", accept);
      end
    end
    ready = 1'b0; Tempbus = ~v;
    @(posedge clk); #1;
    n_cmp++;
    if (accept !== 1'b0) begin
      n_bad++;
      $display("FAIL accept_release: accept=%b want 0 after ready drop", accept);
    end
  endtask

  task automatic start_and_check(input logic [31:0] a, input logic [31:0] b, input string nm);
    logic [31:0] want;
    int cycles, dones;
    want = ref_mul(a, b);
    startMul = 1'b1; cycles = 0; dones = 0;
    while (resultready !== 1'b1 && cycles < 40) begin
      @(posedge clk); #1;
      startMul = 1'b0;
      cycles++;
      if (doneMul === 1'b1) dones++;
    end
    n_cmp++;
    if (cycles != 26) begin
      n_bad++;
      $display("FAIL %s latency: got %0d cycles, want 26", nm, cycles);
    end
    n_cmp++;
    if (ResultBus !== want) begin
      n_bad++;
      $display("FAIL %s result: ResultBus=%h want %h", nm, ResultBus, want);
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (doneMul === 1'b1) dones++;
    end
    n_cmp++;
    if (resultready !== 1'b1 || ResultBus !== want) begin
      n_bad++;
      $display("FAIL %s hold: resultready=%b ResultBus=%h want 1 / %h", nm, resultready, ResultBus, want);
    end
    n_cmp++;
    if (dones != 1) begin
      n_bad++;
      $display("FAIL %s donemul_pulse: %0d cycles high, want 1", nm, dones);
    end
    resultaccept = 1'b1;
    @(posedge clk); #1;
    resultaccept = 1'b0;
    n_cmp++;
    if (resultready !== 1'b0 || ResultBus !== want) begin
      n_bad++;
      $display("FAIL %s accept: resultready=%b ResultBus=%h want 0 / %h", nm, resultready, ResultBus, want);
    end
    $display("op %s: A=%h B=%h -> %h (ref %h) latency %0d", nm, a, b, ResultBus, want, cycles);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string nm);
    load_operand(a, 1);
    load_operand(b, 1);
    start_and_check(a, b, nm);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (accept !== 1'b0 || doneMul !== 1'b0 || resultready !== 1'b0 || ResultBus !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_state: accept=%b doneMul=%b resultready=%b ResultBus=%h want 0/0/0/0",
               accept, doneMul, resultready, ResultBus);
    end
    $display("reset: accept=%b doneMul=%b resultready=%b ResultBus=%h", accept, doneMul, resultready, ResultBus);
  endtask

  task automatic test_handshake();
    load_operand(32'h41440000, 3);
    load_operand(32'hC0600000, 3);
    start_and_check(32'h41440000, 32'hC0600000, "12.25*-3.5");
    n_cmp++;
    if (ResultBus !== 32'hC22B8000) begin
      n_bad++;
      $display("FAIL directed_product: ResultBus=%h want c22b8000", ResultBus);
    end
  endtask

  task automatic test_specials();
    do_reset();
    run_op(32'h40100000, 32'h418C0000, "2.25*17.5");
    n_cmp++;
    if (ResultBus !== 32'h421D8000) begin
      n_bad++;
      $display("FAIL directed_product2: ResultBus=%h want 421d8000", ResultBus);
    end
    run_op(32'h3F800000, 32'h00000000, "one*zero");
    run_op(32'h7F800000, 32'h00000000, "inf*zero");
    run_op(32'h7F000000, 32'h7F000000, "overflow");
    run_op(32'h00800000, 32'h00800000, "underflow");
    run_op(32'hFF800000, 32'h40000000, "-inf*2");
    run_op(32'h7FC12345, 32'h3F800000, "nan*1");
    run_op(32'h80000000, 32'h3F800000, "-zero*1");
  endtask

  task automatic test_reset_mid_mul();
    load_operand(32'h40400000, 1);
    load_operand(32'h40A00000, 1);
    startMul = 1'b1;
    @(posedge clk); #1;
    startMul = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (resultready !== 1'b0 || doneMul !== 1'b0 || accept !== 1'b0 || ResultBus !== 32'h0) begin
      n_bad++;
      $display("FAIL mid_mul_reset: resultready=%b doneMul=%b accept=%b ResultBus=%h want 0/0/0/0",
               resultready, doneMul, accept, ResultBus);
    end
    $display("reset during MUL: resultready=%b doneMul=%b", resultready, doneMul);
    run_op(32'h40400000, 32'h40A00000, "after_reset 3*5");
  endtask

  task automatic test_ready_hold();
    logic [31:0] a, b;
    a = 32'h3FC00000;
    b = 32'h40400000;
    Tempbus = a; ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      Tempbus = b;
      n_cmp++;
      if (accept !== 1'b1) begin
        n_bad++;
        $display("FAIL ready_hold: cycle %0d accept=%b want 1", i, accept);
      end
    end
    ready = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (accept !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_hold_release: accept=%b want 0", accept);
    end
    load_operand(32'h41000000, 1);
    start_and_check(a, 32'h41000000, "ready_hold 1.5*8");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int n = 0; n < 24; n++) begin
      for (int j = 0; j < 2; j++) begin
        logic [7:0] e;
        int sel;
        sel = int'($urandom_range(0, 11));
        if (sel == 0)      e = 8'h00;
        else if (sel == 1) e = 8'hFF;
        else               e = 8'($urandom_range(50, 200));
        if (j == 0) a = {1'($urandom), e, 23'($urandom)};
        else        b = {1'($urandom), e, 23'($urandom)};
      end
      run_op(a, b, "random");
    end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_specials();
    test_reset_mid_mul();
    test_ready_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
